// File: rtl/pet2001ps2_kbd.sv
// PS/2 keyboard to PET 2001 (graphics layout) 10x8 key matrix, read back per PIA1 row select.
// Define PS2_PARITY_CHECK_EN to drop frames whose data+parity bits have even parity.
module pet2001ps2_kbd #(
  parameter int unsigned FILT_LEN    = 8,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [3:0] keyrow,
  output logic [7:0] keyin,
  output logic       key_event,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILT_LEN) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          clk_filt_q;
  logic [FW-1:0] filt_cnt_q;
  logic          filt_done, strobe, rx_data;

  rx_state_e     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          byte_done, rx_err, parity_ok;

  logic [79:0]   matrix_q;
  logic          ext_q, rel_q;
  logic [7:0]    keyin_q, keyin_d;
  logic          key_event_q, frame_err_q;

  logic [8:0]    map_entry;
  logic          map_valid, map_shift;
  logic [3:0]    map_row;
  logic [2:0]    map_col;

  assign rx_data   = data_sync_q[1];
  assign filt_done = (filt_cnt_q == FW'(FILT_LEN - 1));
  // Strobe on the exact cycle the filtered clock commits to low.
  assign strobe    = clk_filt_q & ~clk_sync_q[1] & filt_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_filt_q  <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      if (clk_sync_q[1] == clk_filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_done) begin
        clk_filt_q <= clk_sync_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic parity_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (state_q == StParity && strobe) begin
      parity_q <= rx_data;
    end
  end
  assign parity_ok = ^{shift_q, parity_q};
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tmo_d     = tmo_q;
    byte_done = 1'b0;
    rx_err    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (strobe && !rx_data) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (strobe) begin
          shift_d   = {rx_data, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (strobe) state_d = StStop;
      end
      StStop: begin
        if (strobe) begin
          state_d = StIdle;
          if (rx_data && parity_ok) byte_done = 1'b1;
          else                      rx_err    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_q == StIdle || strobe) begin
      tmo_d = '0;
    end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d = StIdle;
      rx_err  = 1'b1;
      tmo_d   = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tmo_q     <= tmo_d;
    end
  end

  // Entry: {valid, row, col, add_lshift}; shifted PET keys also drive row 8 col 0.
  always_comb begin
    map_entry = '0;
    case ({ext_q, shift_q})
      9'h015: map_entry = {1'b1, 4'd2, 3'd0, 1'b0}; // Q
      9'h024: map_entry = {1'b1, 4'd2, 3'd1, 1'b0}; // E
      9'h02C: map_entry = {1'b1, 4'd2, 3'd2, 1'b0}; // T
      9'h03C: map_entry = {1'b1, 4'd2, 3'd3, 1'b0}; // U
      9'h044: map_entry = {1'b1, 4'd2, 3'd4, 1'b0}; // O
      9'h03D: map_entry = {1'b1, 4'd2, 3'd6, 1'b0}; // 7
      9'h046: map_entry = {1'b1, 4'd2, 3'd7, 1'b0}; // 9
      9'h01D: map_entry = {1'b1, 4'd3, 3'd0, 1'b0}; // W
      9'h02D: map_entry = {1'b1, 4'd3, 3'd1, 1'b0}; // R
      9'h035: map_entry = {1'b1, 4'd3, 3'd2, 1'b0}; // Y
      9'h043: map_entry = {1'b1, 4'd3, 3'd3, 1'b0}; // I
      9'h04D: map_entry = {1'b1, 4'd3, 3'd4, 1'b0}; // P
      9'h03E: map_entry = {1'b1, 4'd3, 3'd6, 1'b0}; // 8
      9'h04A: map_entry = {1'b1, 4'd3, 3'd7, 1'b0}; // /
      9'h14A: map_entry = {1'b1, 4'd3, 3'd7, 1'b0}; // keypad /
      9'h01C: map_entry = {1'b1, 4'd4, 3'd0, 1'b0}; // A
      9'h023: map_entry = {1'b1, 4'd4, 3'd1, 1'b0}; // D
      9'h034: map_entry = {1'b1, 4'd4, 3'd2, 1'b0}; // G
      9'h03B: map_entry = {1'b1, 4'd4, 3'd3, 1'b0}; // J
      9'h04B: map_entry = {1'b1, 4'd4, 3'd4, 1'b0}; // L
      9'h025: map_entry = {1'b1, 4'd4, 3'd6, 1'b0}; // 4
      9'h036: map_entry = {1'b1, 4'd4, 3'd7, 1'b0}; // 6
      9'h01B: map_entry = {1'b1, 4'd5, 3'd0, 1'b0}; // S
      9'h02B: map_entry = {1'b1, 4'd5, 3'd1, 1'b0}; // F
      9'h033: map_entry = {1'b1, 4'd5, 3'd2, 1'b0}; // H
      9'h042: map_entry = {1'b1, 4'd5, 3'd3, 1'b0}; // K
      9'h02E: map_entry = {1'b1, 4'd5, 3'd6, 1'b0}; // 5
      9'h01A: map_entry = {1'b1, 4'd6, 3'd0, 1'b0}; // Z
      9'h021: map_entry = {1'b1, 4'd6, 3'd1, 1'b0}; // C
      9'h032: map_entry = {1'b1, 4'd6, 3'd2, 1'b0}; // B
      9'h03A: map_entry = {1'b1, 4'd6, 3'd3, 1'b0}; // M
      9'h04C: map_entry = {1'b1, 4'd6, 3'd4, 1'b0}; // ;
      9'h05A: map_entry = {1'b1, 4'd6, 3'd5, 1'b0}; // Return
      9'h15A: map_entry = {1'b1, 4'd6, 3'd5, 1'b0}; // keypad Enter
      9'h016: map_entry = {1'b1, 4'd6, 3'd6, 1'b0}; // 1
      9'h026: map_entry = {1'b1, 4'd6, 3'd7, 1'b0}; // 3
      9'h022: map_entry = {1'b1, 4'd7, 3'd0, 1'b0}; // X
      9'h02A: map_entry = {1'b1, 4'd7, 3'd1, 1'b0}; // V
      9'h031: map_entry = {1'b1, 4'd7, 3'd2, 1'b0}; // N
      9'h041: map_entry = {1'b1, 4'd7, 3'd3, 1'b0}; // ,
      9'h01E: map_entry = {1'b1, 4'd7, 3'd6, 1'b0}; // 2
      9'h012: map_entry = {1'b1, 4'd8, 3'd0, 1'b0}; // LShift
      9'h059: map_entry = {1'b1, 4'd8, 3'd5, 1'b0}; // RShift
      9'h045: map_entry = {1'b1, 4'd8, 3'd6, 1'b0}; // 0
      9'h029: map_entry = {1'b1, 4'd9, 3'd2, 1'b0}; // Space
      9'h076: map_entry = {1'b1, 4'd9, 3'd4, 1'b0}; // Esc -> STOP
      9'h049: map_entry = {1'b1, 4'd9, 3'd6, 1'b0}; // .
      9'h16C: map_entry = {1'b1, 4'd0, 3'd6, 1'b0}; // Home
      9'h174: map_entry = {1'b1, 4'd0, 3'd7, 1'b0}; // Right
      9'h16B: map_entry = {1'b1, 4'd0, 3'd7, 1'b1}; // Left = shift + Right
      9'h172: map_entry = {1'b1, 4'd1, 3'd6, 1'b0}; // Down
      9'h175: map_entry = {1'b1, 4'd1, 3'd6, 1'b1}; // Up = shift + Down
      9'h066: map_entry = {1'b1, 4'd1, 3'd7, 1'b0}; // Backspace -> DEL
      default: map_entry = '0;
    endcase
  end

  assign {map_valid, map_row, map_col, map_shift} = map_entry;

  always_comb begin
    keyin_d = 8'hFF;
    if (keyrow <= 4'd9) keyin_d = matrix_q[{keyrow, 3'b000} +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      matrix_q    <= '1;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      keyin_q     <= 8'hFF;
      key_event_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      keyin_q     <= keyin_d;
      key_event_q <= 1'b0;
      frame_err_q <= rx_err;
      if (byte_done) begin
        case (shift_q)
          8'hE0: ext_q <= 1'b1;
          8'hF0: rel_q <= 1'b1;
          8'hAA: begin
            matrix_q <= '1;
            ext_q    <= 1'b0;
            rel_q    <= 1'b0;
          end
          default: begin
            ext_q <= 1'b0;
            rel_q <= 1'b0;
            if (map_valid) begin
              matrix_q[{map_row, map_col}] <= rel_q;
              if (map_shift) matrix_q[7'd64] <= rel_q;
              key_event_q <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign keyin     = keyin_q;
  assign key_event = key_event_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_pet2001ps2_kbd.sv
// Self-checking bench for pet2001ps2_kbd: directed vector table, corner sequences,
// then randomized make/break traffic checked against a key-matrix model.
module tb_pet2001ps2_kbd;

  localparam int unsigned Filt = 8;
  localparam int unsigned Tmo  = 300;

  logic       clk = 1'b0;
  logic       reset, ps2_clk, ps2_data;
  logic [3:0] keyrow;
  logic [7:0] keyin;
  logic       key_event, frame_err;

  int checks = 0, errors = 0;
  int ev_cnt = 0, err_cnt = 0;

  pet2001ps2_kbd #(.FILT_LEN(Filt), .TIMEOUT_CYC(Tmo)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keyrow    (keyrow),
    .keyin     (keyin),
    .key_event (key_event),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_event === 1'b1) ev_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          n;
    logic [23:0] bytes;
    logic [3:0]  row;
    logic [7:0]  exp;
    int          ev;
  } vec_t;

  typedef struct {
    logic       ext;
    logic [7:0] code;
    bit         mapped;
    int         row;
    int         col;
    bit         shift;
  } key_t;

  vec_t       vecs[17];
  key_t       keys[8];
  logic [7:0] mdl[10];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(10);
    ps2_clk = 1'b0;
    tick(20);
    ps2_clk = 1'b1;
    tick(10);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic par_flip, input logic stop);
    logic [10:0] f;
    f = {stop, (~^code) ^ par_flip, code, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    ps2_data = 1'b1;
    tick(20);
  endtask

  task automatic send_byte(input logic [7:0] code);
    send_frame(code, 1'b0, 1'b1);
  endtask

  task automatic check_row(input string name, input logic [3:0] r, input logic [7:0] exp);
    keyrow = r;
    tick(2);
    @(negedge clk);
    check8(name, keyin, exp);
  endtask

  initial begin
    int         ev0, er0;
    logic [7:0] b;
    key_t       k;
    bit         brk;
    logic [3:0] r;
    logic [7:0] e;

    vecs[0]  = '{1, 24'h1C0000, 4'd4,  8'hFE, 1};
    vecs[1]  = '{1, 24'hF00000, 4'd4,  8'hFE, 0};
    vecs[2]  = '{1, 24'h1C0000, 4'd4,  8'hFF, 1};
    vecs[3]  = '{1, 24'h120000, 4'd8,  8'hFE, 1};
    vecs[4]  = '{1, 24'h290000, 4'd9,  8'hFB, 1};
    vecs[5]  = '{0, 24'h000000, 4'd12, 8'hFF, 0};
    vecs[6]  = '{2, 24'hE06B00, 4'd0,  8'h7F, 1};
    vecs[7]  = '{0, 24'h000000, 4'd8,  8'hFE, 0};
    vecs[8]  = '{3, 24'hE0F06B, 4'd0,  8'hFF, 1};
    vecs[9]  = '{0, 24'h000000, 4'd8,  8'hFF, 0};
    vecs[10] = '{2, 24'hF02900, 4'd9,  8'hFF, 1};
    vecs[11] = '{2, 24'hE00500, 4'd0,  8'hFF, 0};
    vecs[12] = '{1, 24'h1C0000, 4'd4,  8'hFE, 1};
    vecs[13] = '{2, 24'hF01C00, 4'd4,  8'hFF, 1};
    vecs[14] = '{2, 24'hF05A00, 4'd6,  8'hFF, 1};
    vecs[15] = '{1, 24'h590000, 4'd8,  8'hDF, 1};
    vecs[16] = '{2, 24'hF05900, 4'd8,  8'hFF, 1};

    keys[0] = '{1'b0, 8'h1C, 1'b1, 4, 0, 1'b0};
    keys[1] = '{1'b0, 8'h5A, 1'b1, 6, 5, 1'b0};
    keys[2] = '{1'b0, 8'h12, 1'b1, 8, 0, 1'b0};
    keys[3] = '{1'b0, 8'h59, 1'b1, 8, 5, 1'b0};
    keys[4] = '{1'b0, 8'h29, 1'b1, 9, 2, 1'b0};
    keys[5] = '{1'b0, 8'h15, 1'b1, 2, 0, 1'b0};
    keys[6] = '{1'b1, 8'h6B, 1'b1, 0, 7, 1'b1};
    keys[7] = '{1'b0, 8'h05, 1'b0, 0, 0, 1'b0};

    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; keyrow = 4'd0;
    tick(4);
    @(negedge clk);
    check8("reset_keyin", keyin, 8'hFF);
    check8("reset_key_event", {7'd0, key_event}, 8'h00);
    check8("reset_frame_err", {7'd0, frame_err}, 8'h00);
    reset = 1'b0;
    tick(5);

    er0 = err_cnt;
    for (int v = 0; v < 17; v++) begin
      ev0 = ev_cnt;
      for (int i = 0; i < vecs[v].n; i++) begin
        b = vecs[v].bytes[23 - 8*i -: 8];
        send_byte(b);
      end
      check_row($sformatf("vec%0d_keyin", v), vecs[v].row, vecs[v].exp);
      check_int($sformatf("vec%0d_events", v), ev_cnt - ev0, vecs[v].ev);
    end
    check_int("vec_no_frame_err", err_cnt - er0, 0);

    // Bad stop bit: byte dropped, error pulse.
    ev0 = ev_cnt; er0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b0);
    check_int("badstop_err", err_cnt - er0, 1);
    check_int("badstop_events", ev_cnt - ev0, 0);
    check_row("badstop_row4", 4'd4, 8'hFF);

    // Clock stalls after 4 bits: timeout, then a clean frame still decodes.
    er0 = err_cnt;
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    ps2_data = 1'b1;
    tick(Tmo + 60);
    check_int("timeout_err", err_cnt - er0, 1);
    ev0 = ev_cnt;
    send_byte(8'h5A);
    check_row("after_timeout_row6", 4'd6, 8'hDF);
    check_int("after_timeout_events", ev_cnt - ev0, 1);
    send_byte(8'hF0); send_byte(8'h5A);

    // Parity bit flipped.
    er0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    check_int("parity_err", err_cnt - er0, 1);
    check_row("parity_row4", 4'd4, 8'hFF);
`else
    check_int("parity_ignored_err", err_cnt - er0, 0);
    check_row("parity_ignored_row4", 4'd4, 8'hFE);
    send_byte(8'hF0); send_byte(8'h1C);
`endif

    // Reset in the middle of a frame after F0: the release flag must not survive.
    send_byte(8'hF0);
    send_bit(1'b0); send_bit(1'b1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    ps2_data = 1'b1;
    tick(5);
    send_byte(8'h1C);
    check_row("reset_midframe_row4", 4'd4, 8'hFE);

    // Self-test AA wipes the matrix and the ext flag.
    send_byte(8'h29);
    send_byte(8'hE0);
    send_byte(8'hAA);
    for (int i = 0; i < 10; i++) check_row($sformatf("aa_row%0d", i), 4'(i), 8'hFF);
    send_byte(8'h1C);
    check_row("aa_flags_cleared_row4", 4'd4, 8'hFE);
    send_byte(8'hAA);
    for (int i = 0; i < 10; i++) mdl[i] = 8'hFF;

    // Random make/break traffic against the key-matrix model.
    for (int it = 0; it < 30; it++) begin
      k   = keys[$urandom_range(0, 7)];
      brk = 1'($urandom_range(0, 1));
      ev0 = ev_cnt;
      if (k.ext) send_byte(8'hE0);
      if (brk)   send_byte(8'hF0);
      send_byte(k.code);
      if (k.mapped) begin
        mdl[k.row][k.col] = brk;
        if (k.shift) mdl[8][0] = brk;
      end
      r = 4'($urandom_range(0, 15));
      e = (r <= 4'd9) ? mdl[r] : 8'hFF;
      check_row($sformatf("rand%0d_row%0d", it, r), r, e);
      check_int($sformatf("rand%0d_events", it), ev_cnt - ev0, k.mapped ? 1 : 0);
    end
    for (int i = 0; i < 16; i++) begin
      e = (i <= 9) ? mdl[i] : 8'hFF;
      check_row($sformatf("final_row%0d", i), 4'(i), e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
